// File: rtl/parity_pkg.sv
// parity_pkg: shared state encoding, frame width and parity helper for the parity serial path
package parity_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam int FRAME_DATA_BITS = 8;
  function automatic logic parity_of(input logic [7:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/parity_serial_rx_if.sv
// parity_serial_rx_if: serial line in, received byte and status out
interface parity_serial_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  modport master (output rx, input data, valid, parity_err, frame_err, busy);
  modport slave  (input rx, output data, valid, parity_err, frame_err, busy);
endinterface

// File: rtl/parity_serial_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // first flop may go metastable; second gives it a full cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/parity_serial_rx.sv
// parity_serial_rx: mid-bit sampling receiver for start/8 data/parity/stop frames with error flags
module parity_serial_rx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit EVEN_PARITY  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  parity_serial_rx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);
  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;
  logic          rx_s;
  logic [2:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          p;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          parity_err_q;
  logic          frame_err_q;
  logic          bit_done;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.rx),
    .q    (rx_s)
  );
  assign bit_done       = clk_cnt == FULL;
  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = state != ST_IDLE;
  // frame FSM: after the half-bit start check every later sample lands mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      p            <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: if (!rx_s) begin
          state   <= ST_START;
          clk_cnt <= '0;
        end
        ST_START: if (clk_cnt == HALF) begin
          clk_cnt <= '0;
          bit_idx <= '0;
          state   <= rx_s ? ST_IDLE : ST_DATA;
        end else clk_cnt <= clk_cnt + 1'b1;
        ST_DATA: if (bit_done) begin
          shift[bit_idx] <= rx_s;
          clk_cnt        <= '0;
          bit_idx        <= bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state <= ST_PARITY;
        end else clk_cnt <= clk_cnt + 1'b1;
        ST_PARITY: if (bit_done) begin
          p       <= rx_s;
          clk_cnt <= '0;
          state   <= ST_STOP;
        end else clk_cnt <= clk_cnt + 1'b1;
        ST_STOP: if (bit_done) begin
          data_q       <= shift;
          parity_err_q <= (parity_of(shift) ^ p) != ~EVEN_PARITY;
          frame_err_q  <= ~rx_s;
          valid_q      <= 1'b1;
          clk_cnt      <= '0;
          state        <= ST_IDLE;
        end else clk_cnt <= clk_cnt + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
